// File: rtl/uart_rx_cfg.sv
// Runtime-configurable UART receiver: 16x oversampling, 2-of-3 majority vote, 5-8 data bits,
// optional parity, 1/2 stop bits, break detection, valid/ready output. Optional noise flag: UART_RX_NOISE_FLAG_EN.
module uart_rx_cfg #(
  parameter int DIV_W       = 16,
  parameter int SYNC_STAGES = 2
) (
  input  logic             i_clk,
  input  logic             i_srst,
  input  logic             i_rx_en,
  input  logic [DIV_W-1:0] i_cfg_baud_div,
  input  logic [1:0]       i_cfg_data_bits,
  input  logic [1:0]       i_cfg_parity,
  input  logic             i_cfg_stop2,
  input  logic             i_rx_serial,
  input  logic             i_rx_ready,
  input  logic             i_rx_clr_ovr,
  output logic [7:0]       o_rx_data,
  output logic             o_rx_valid,
  output logic             o_rx_frame_err,
  output logic             o_rx_parity_err,
  output logic             o_rx_break,
  output logic             o_rx_overrun,
  output logic             o_rx_busy,
  output logic             o_rx_noise
);

  // state    | meaning
  // IDLE     | waiting for a start edge
  // START    | start bit, false-start check at its vote point
  // DATA     | data bits, LSB first
  // PARITY   | parity bit
  // STOP1    | first stop bit
  // STOP2    | second stop bit
  // DONE     | one clock: deliver word or flag overrun
  // BRK_WAIT | break seen, waiting for the line to return high
  localparam logic [2:0] S_IDLE   = 3'd0;
  localparam logic [2:0] S_START  = 3'd1;
  localparam logic [2:0] S_DATA   = 3'd2;
  localparam logic [2:0] S_PARITY = 3'd3;
  localparam logic [2:0] S_STOP1  = 3'd4;
  localparam logic [2:0] S_STOP2  = 3'd5;
  localparam logic [2:0] S_DONE   = 3'd6;
  localparam logic [2:0] S_BRK    = 3'd7;

  logic [SYNC_STAGES-1:0] r_sync;
  logic                   r_rx_prev;
  logic [DIV_W-1:0]       r_div;
  logic [3:0]             r_smp;
  logic                   r_v0, r_v1;
  logic [2:0]             r_state;
  logic [2:0]             r_bit_cnt;
  logic [1:0]             r_nbits;
  logic [1:0]             r_par;
  logic                   r_stop2;
  logic [7:0]             r_shift;
  logic                   r_xor, r_zero, r_par_err, r_frm_err;
  logic [7:0]             r_data;
  logic                   r_valid, r_fe, r_pe, r_brk, r_ovr;

  logic w_rx, w_start, w_tick, w_eval, w_end, w_maj, w_last_bit, w_par_en, w_done, w_accept;
  logic [7:0] w_data_rj;

  assign w_rx       = r_sync[SYNC_STAGES-1];
  assign w_start    = (r_state == S_IDLE) && i_rx_en && r_rx_prev && !w_rx;
  assign w_tick     = i_rx_en && (r_div == '0);
  assign w_eval     = w_tick && (r_smp == 4'd9);
  assign w_end      = w_tick && (r_smp == 4'd15);
  assign w_maj      = (r_v0 & r_v1) | (r_v0 & w_rx) | (r_v1 & w_rx);
  assign w_last_bit = (r_bit_cnt == ({1'b0, r_nbits} + 3'd4));
  assign w_par_en   = r_par[0] ^ r_par[1];
  assign w_done     = (r_state == S_DONE) && i_rx_en;
  assign w_accept   = !r_valid || i_rx_ready;
  assign w_data_rj  = r_shift >> (2'd3 - r_nbits);

  always_ff @(posedge i_clk) begin
    if (i_srst) begin
      r_sync    <= '1;
      r_rx_prev <= 1'b1;
      r_div     <= '0;
      r_smp     <= '0;
      r_v0      <= 1'b0;
      r_v1      <= 1'b0;
    end else begin
      r_sync    <= {r_sync[SYNC_STAGES-2:0], i_rx_serial};
      r_rx_prev <= w_rx;
      if (i_rx_en) begin
        if (w_start || w_tick) r_div <= i_cfg_baud_div;
        else                   r_div <= r_div - {{(DIV_W-1){1'b0}}, 1'b1};
      end
      if (w_start)     r_smp <= '0;
      else if (w_tick) r_smp <= r_smp + 4'd1;
      if (w_tick && r_smp == 4'd7) r_v0 <= w_rx;
      if (w_tick && r_smp == 4'd8) r_v1 <= w_rx;
    end
  end

  always_ff @(posedge i_clk) begin
    if (i_srst) begin
      r_state   <= S_IDLE;
      r_bit_cnt <= '0;
      r_nbits   <= '0;
      r_par     <= '0;
      r_stop2   <= 1'b0;
      r_shift   <= '0;
      r_xor     <= 1'b0;
      r_zero    <= 1'b0;
      r_par_err <= 1'b0;
      r_frm_err <= 1'b0;
    end else if (!i_rx_en) begin
      r_state <= S_IDLE;
    end else begin
      case (r_state)
        S_IDLE: if (w_start) begin
          r_state   <= S_START;
          r_nbits   <= i_cfg_data_bits;
          r_par     <= i_cfg_parity;
          r_stop2   <= i_cfg_stop2;
          r_bit_cnt <= '0;
          r_xor     <= 1'b0;
          r_zero    <= 1'b1;
          r_par_err <= 1'b0;
          r_frm_err <= 1'b0;
        end
        S_START: begin
          if (w_eval && w_maj) r_state <= S_IDLE;
          else if (w_end)      r_state <= S_DATA;
        end
        S_DATA: begin
          if (w_eval) begin
            r_shift <= {w_maj, r_shift[7:1]};
            r_xor   <= r_xor ^ w_maj;
            r_zero  <= r_zero & !w_maj;
          end
          if (w_end) begin
            if (w_last_bit) r_state <= w_par_en ? S_PARITY : S_STOP1;
            else            r_bit_cnt <= r_bit_cnt + 3'd1;
          end
        end
        S_PARITY: begin
          // odd (2'b10) expects XOR of data and parity bit to be 1, even expects 0
          if (w_eval) begin
            r_par_err <= ((r_xor ^ w_maj) != r_par[1]);
            r_zero    <= r_zero & !w_maj;
          end
          if (w_end) r_state <= S_STOP1;
        end
        S_STOP1: begin
          if (w_eval) begin
            r_frm_err <= !w_maj;
            r_zero    <= r_zero & !w_maj;
            if (!r_stop2) r_state <= S_DONE;
          end else if (w_end) begin
            r_state <= S_STOP2;
          end
        end
        S_STOP2: if (w_eval) begin
          r_frm_err <= r_frm_err | !w_maj;
          r_state   <= S_DONE;
        end
        S_DONE:  r_state <= r_zero ? S_BRK : S_IDLE;
        S_BRK:   if (w_rx) r_state <= S_IDLE;
        default: r_state <= S_IDLE;
      endcase
    end
  end

  always_ff @(posedge i_clk) begin
    if (i_srst) begin
      r_data  <= '0;
      r_valid <= 1'b0;
      r_fe    <= 1'b0;
      r_pe    <= 1'b0;
      r_brk   <= 1'b0;
      r_ovr   <= 1'b0;
    end else begin
      if (w_done && w_accept) begin
        r_data  <= w_data_rj;
        r_fe    <= r_frm_err;
        r_pe    <= r_par_err;
        r_brk   <= r_zero;
        r_valid <= 1'b1;
      end else if (r_valid && i_rx_ready) begin
        r_valid <= 1'b0;
      end
      if (w_done && !w_accept) r_ovr <= 1'b1;
      else if (i_rx_clr_ovr)   r_ovr <= 1'b0;
    end
  end

`ifdef UART_RX_NOISE_FLAG_EN
  logic r_noise_acc, r_noise_out;
  logic w_disagree;
  assign w_disagree = (r_v0 != r_v1) || (r_v1 != w_rx);

  always_ff @(posedge i_clk) begin
    if (i_srst) begin
      r_noise_acc <= 1'b0;
      r_noise_out <= 1'b0;
    end else begin
      if (w_start)
        r_noise_acc <= 1'b0;
      else if (w_eval && (r_state inside {S_START, S_DATA, S_PARITY, S_STOP1, S_STOP2}))
        r_noise_acc <= r_noise_acc | w_disagree;
      if (w_done && w_accept) r_noise_out <= r_noise_acc;
    end
  end
  assign o_rx_noise = r_noise_out;
`else
  assign o_rx_noise = 1'b0;
`endif

  assign o_rx_data       = r_data;
  assign o_rx_valid      = r_valid;
  assign o_rx_frame_err  = r_fe;
  assign o_rx_parity_err = r_pe;
  assign o_rx_break      = r_brk;
  assign o_rx_overrun    = r_ovr;
  assign o_rx_busy       = (r_state != S_IDLE);

endmodule

// File: tb/tb_uart_rx_cfg.sv
// Self-checking bench for uart_rx_cfg: scoreboard of expected words popped on each accepted transfer.
module tb_uart_rx_cfg;

  logic        clk = 1'b0;
  logic        srst, rx_en, cfg_stop2, rx_serial, rx_ready, rx_clr_ovr;
  logic [15:0] cfg_baud_div;
  logic [1:0]  cfg_data_bits, cfg_parity;
  logic [7:0]  rx_data;
  logic        rx_valid, rx_frame_err, rx_parity_err, rx_break, rx_overrun, rx_busy, rx_noise;

  always #5 clk = ~clk;

  uart_rx_cfg #(.DIV_W(16), .SYNC_STAGES(2)) dut (
    .i_clk(clk), .i_srst(srst), .i_rx_en(rx_en), .i_cfg_baud_div(cfg_baud_div),
    .i_cfg_data_bits(cfg_data_bits), .i_cfg_parity(cfg_parity), .i_cfg_stop2(cfg_stop2),
    .i_rx_serial(rx_serial), .i_rx_ready(rx_ready), .i_rx_clr_ovr(rx_clr_ovr),
    .o_rx_data(rx_data), .o_rx_valid(rx_valid), .o_rx_frame_err(rx_frame_err),
    .o_rx_parity_err(rx_parity_err), .o_rx_break(rx_break), .o_rx_overrun(rx_overrun),
    .o_rx_busy(rx_busy), .o_rx_noise(rx_noise)
  );

`ifdef UART_RX_NOISE_FLAG_EN
  localparam logic NZ = 1'b1;
`else
  localparam logic NZ = 1'b0;
`endif

  typedef struct packed {
    logic [7:0] d;
    logic       fe;
    logic       pe;
    logic       brk;
    logic       nz;
  } exp_t;

  exp_t sb[$];
  exp_t mon_e;
  int   n_chk = 0;
  int   n_err = 0;
  int   div_cur = 3;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic push(input logic [7:0] d, input logic fe, input logic pe, input logic brk, input logic nz);
    exp_t e;
    e.d = d; e.fe = fe; e.pe = pe; e.brk = brk; e.nz = nz;
    sb.push_back(e);
  endtask

  // par: 0 none, 1 even, 2 odd; glitch_c >= 0 inverts the line for one sample tick from that clock
  task automatic send_frame(input logic [7:0] d, input int nbits, input int par, input bit bad_par,
                            input bit two_stop, input int glitch_c);
    logic [11:0] fb;
    int          len, bper;
    logic        p, g;
    bper  = 16 * (div_cur + 1);
    fb    = '1;
    fb[0] = 1'b0;
    p     = 1'b0;
    for (int i = 0; i < nbits; i++) begin
      fb[1+i] = d[i];
      p       = p ^ d[i];
    end
    len = 1 + nbits;
    if (par != 0) begin
      if (par == 2) p = ~p;
      if (bad_par)  p = ~p;
      fb[len] = p;
      len++;
    end
    fb[len] = 1'b1;
    len++;
    if (two_stop) begin
      fb[len] = 1'b1;
      len++;
    end
    for (int c = 0; c < len * bper; c++) begin
      g = (glitch_c >= 0 && c >= glitch_c && c < glitch_c + div_cur + 1) ? 1'b1 : 1'b0;
      rx_serial = fb[c / bper] ^ g;
      tick(1);
    end
    rx_serial = 1'b1;
  endtask

  task automatic wait_drain();
    for (int i = 0; i < 3000 && sb.size() != 0; i++) tick(1);
    chk("drain", 32'(sb.size()), 32'd0);
  endtask

  task automatic chk_all_zero(input string tag);
    chk({tag, "_data"},  32'(rx_data), 32'd0);
    chk({tag, "_valid"}, 32'(rx_valid), 32'd0);
    chk({tag, "_fe"},    32'(rx_frame_err), 32'd0);
    chk({tag, "_pe"},    32'(rx_parity_err), 32'd0);
    chk({tag, "_brk"},   32'(rx_break), 32'd0);
    chk({tag, "_ovr"},   32'(rx_overrun), 32'd0);
    chk({tag, "_busy"},  32'(rx_busy), 32'd0);
    chk({tag, "_noise"}, 32'(rx_noise), 32'd0);
  endtask

  always @(negedge clk) begin
    if (!srst && rx_valid && rx_ready) begin
      if (sb.size() == 0) begin
        chk("sb_unexpected_word", 32'(rx_data), 32'hFFFF_FFFF);
      end else begin
        mon_e = sb.pop_front();
        chk("rx_data",  32'(rx_data), 32'(mon_e.d));
        chk("rx_fe",    32'(rx_frame_err), 32'(mon_e.fe));
        chk("rx_pe",    32'(rx_parity_err), 32'(mon_e.pe));
        chk("rx_break", 32'(rx_break), 32'(mon_e.brk));
        chk("rx_noise", 32'(rx_noise), 32'(mon_e.nz));
      end
    end
  end

  initial begin
    #1_000_000;
    $display("FAIL watchdog expired");
    $fatal(1, "watchdog");
  end

  initial begin
    int bad;
    srst = 1'b1; rx_en = 1'b0; rx_serial = 1'b1; rx_ready = 1'b0; rx_clr_ovr = 1'b0;
    cfg_baud_div = 16'd3; cfg_data_bits = 2'd3; cfg_parity = 2'b00; cfg_stop2 = 1'b0;
    tick(3);
    @(negedge clk);
    chk_all_zero("reset");
    srst = 1'b0;
    rx_en = 1'b1;
    tick(10);

    // 8N1 0xA5 held with ready low, then single-clock ready
    push(8'hA5, 1'b0, 1'b0, 1'b0, 1'b0);
    send_frame(8'hA5, 8, 0, 1'b0, 1'b0, -1);
    @(negedge clk);
    chk("t1_valid", 32'(rx_valid), 32'd1);
    bad = 0;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      if (rx_data !== 8'hA5 || rx_valid !== 1'b1) bad++;
    end
    chk("t1_stable", 32'(bad), 32'd0);
    tick(1);
    rx_ready = 1'b1;
    tick(1);
    rx_ready = 1'b0;
    @(negedge clk);
    chk("t1_valid_clr", 32'(rx_valid), 32'd0);
    chk("t1_popped", 32'(sb.size()), 32'd0);

    // 7E2 at div 0: bad then good parity
    tick(1);
    div_cur = 0;
    cfg_baud_div = 16'd0; cfg_data_bits = 2'd2; cfg_parity = 2'b01; cfg_stop2 = 1'b1;
    rx_ready = 1'b1;
    tick(20);
    push(8'h35, 1'b0, 1'b1, 1'b0, 1'b0);
    send_frame(8'h35, 7, 1, 1'b1, 1'b1, -1);
    push(8'h35, 1'b0, 1'b0, 1'b0, 1'b0);
    send_frame(8'h35, 7, 1, 1'b0, 1'b1, -1);
    wait_drain();

    // false start, then a clean 0x3C
    div_cur = 3;
    cfg_baud_div = 16'd3; cfg_data_bits = 2'd3; cfg_parity = 2'b00; cfg_stop2 = 1'b0;
    tick(20);
    rx_serial = 1'b0;
    tick(20);
    rx_serial = 1'b1;
    tick(10);
    @(negedge clk);
    chk("t3_busy_start", 32'(rx_busy), 32'd1);
    tick(30);
    @(negedge clk);
    chk("t3_busy_idle", 32'(rx_busy), 32'd0);
    tick(1);
    push(8'h3C, 1'b0, 1'b0, 1'b0, 1'b0);
    send_frame(8'h3C, 8, 0, 1'b0, 1'b0, -1);
    wait_drain();

    // break: 12 bit times low
    tick(10);
    push(8'h00, 1'b1, 1'b0, 1'b1, 1'b0);
    rx_serial = 1'b0;
    tick(12 * 64);
    @(negedge clk);
    chk("t4_busy_brk", 32'(rx_busy), 32'd1);
    chk("t4_brk_delivered", 32'(sb.size()), 32'd0);
    rx_serial = 1'b1;
    tick(10);
    @(negedge clk);
    chk("t4_busy_release", 32'(rx_busy), 32'd0);
    tick(1);
    push(8'h81, 1'b0, 1'b0, 1'b0, 1'b0);
    send_frame(8'h81, 8, 0, 1'b0, 1'b0, -1);
    wait_drain();

    // overrun, clear, drain, then reset mid-frame
    rx_ready = 1'b0;
    tick(10);
    push(8'h11, 1'b0, 1'b0, 1'b0, 1'b0);
    send_frame(8'h11, 8, 0, 1'b0, 1'b0, -1);
    send_frame(8'h22, 8, 0, 1'b0, 1'b0, -1);
    @(negedge clk);
    chk("t5_data_kept", 32'(rx_data), 32'h11);
    chk("t5_ovr_set", 32'(rx_overrun), 32'd1);
    chk("t5_valid", 32'(rx_valid), 32'd1);
    tick(1);
    rx_clr_ovr = 1'b1;
    tick(1);
    rx_clr_ovr = 1'b0;
    @(negedge clk);
    chk("t5_ovr_clr", 32'(rx_overrun), 32'd0);
    tick(1);
    rx_ready = 1'b1;
    wait_drain();
    rx_ready = 1'b0;
    tick(5);
    send_frame(8'h77, 8, 0, 1'b0, 1'b0, -1);
    rx_serial = 1'b0;
    tick(100);
    @(negedge clk);
    chk("t5_pre_busy", 32'(rx_busy), 32'd1);
    chk("t5_pre_valid", 32'(rx_valid), 32'd1);
    srst = 1'b1;
    tick(1);
    @(negedge clk);
    chk_all_zero("t5_srst");
    srst = 1'b0;
    rx_serial = 1'b1;
    tick(10);

    // rx_en drop mid-frame aborts reception
    rx_ready = 1'b1;
    rx_serial = 1'b0;
    tick(100);
    @(negedge clk);
    chk("en_busy", 32'(rx_busy), 32'd1);
    rx_en = 1'b0;
    tick(1);
    @(negedge clk);
    chk("en_abort", 32'(rx_busy), 32'd0);
    rx_serial = 1'b1;
    tick(5);
    rx_en = 1'b1;
    tick(200);

    // glitch on sample 8 of data bit 2
    push(8'h5A, 1'b0, 1'b0, 1'b0, NZ);
    send_frame(8'h5A, 8, 0, 1'b0, 1'b0, 226);
    wait_drain();

    tick(50);
    chk("sb_end", 32'(sb.size()), 32'd0);
    $display("CHECKS %0d ERRORS %0d", n_chk, n_err);
    $finish;
  end

endmodule

// File: doc/uart_rx_cfg.md
Name: uart_rx_cfg

Overview:
Parametrised, runtime-configurable UART receiver and successor to the fixed 8N1 receiver. It provides 16x oversampling with 3-sample majority voting, 5-8 data bits, optional even/odd parity, and 1 or 2 stop bits. It also detects break conditions and uses a valid/ready output handshake with overrun detection. It sits between the pad synchroniser input and the APB register/FIFO layer.

Parameters:
DIV_W, 16, width of the sample-tick divider.
SYNC_STAGES, 2, number of input synchroniser flops (minimum 2).

Ports:
clk  in  1  system clock
srst  in  1  synchronous active-high reset
rx_en  in  1  receiver enable; deassertion aborts any frame in progress
cfg_baud_div  in  DIV_W  sample tick every cfg_baud_div+1 clocks (16 ticks per bit)
cfg_data_bits  in  2  0=5, 1=6, 2=7, 3=8 data bits
cfg_parity  in  2  00/11 none, 01 even, 10 odd
cfg_stop2  in  1  1 = two stop bits
rx_serial  in  1  asynchronous serial input, idle high
rx_ready  in  1  consumer accepts rx_data this cycle
rx_clr_ovr  in  1  clears the sticky rx_overrun flag
rx_data  out  8  received word, right-justified, upper bits zero
rx_valid  out  1  rx_data and its status flags are valid
rx_frame_err  out  1  stop bit sampled low (qualified by rx_valid)
rx_parity_err  out  1  parity mismatch (qualified by rx_valid)
rx_break  out  1  break detected (qualified by rx_valid)
rx_overrun  out  1  sticky: a frame completed while rx_valid was pending
rx_busy  out  1  frame reception in progress
rx_noise  out  1  see Optional Feature

Behaviour:
- Reset: clk rising edge with srst=1.
  - All outputs 0.
  - Synchroniser flops 1, FSM in IDLE, tick divider 0.
- Synchroniser: SYNC_STAGES flops. The start edge is synced-previous=1 and synced=0.
- Tick divider:
  - Runs only while rx_en=1.
  - Counts down and emits a one-clock tick at 0, then reloads cfg_baud_div.
  - cfg_baud_div=0 gives a tick every clock.
  - Restarts from cfg_baud_div on start-edge detection so bit phase aligns to the edge.
- Bit timing:
  - A 4-bit sample counter runs 0..15 per bit on ticks.
  - Samples are taken at counts 7, 8 and 9; the bit value is the 2-of-3 majority, resolved at count 9.
  - A bit ends at count 15.
- Config latching: cfg_data_bits, cfg_parity and cfg_stop2 are latched on start-edge detection. Changes mid-frame have no effect.
- FSM states and transitions:
  - IDLE: on start edge with rx_en=1, go to START and set rx_busy=1.
  - START: if the majority is 1 at count 9, this is a false start: go to IDLE, rx_busy=0, no flags. Otherwise go to DATA at end of bit.
  - DATA: shift LSB first. After the latched number of bits, go to PARITY if parity is enabled, else STOP1.
  - PARITY: parity_err = (XOR of data bits XOR parity bit) != expected, where even expects 0 and odd expects 1.
  - STOP1:
    - At count 9 a low sample sets frame_err.
    - If cfg_stop2=1, stay for the full bit, then go to STOP2.
    - Otherwise go to DONE immediately at count 9 (half-bit early completion for resync).
  - STOP2: evaluate frame_err at count 9 the same way (OR with the STOP1 result), then go to DONE.
  - DONE (one clock):
    - If rx_valid=0, or rx_ready=1 this cycle: load rx_data and the flags, and set rx_valid the next cycle.
    - Otherwise: drop the new word, keep the old data and flags, and set rx_overrun.
    - Then: if break, go to BRK_WAIT; else go to IDLE with rx_busy=0.
  - BRK_WAIT: rx_busy stays 1. Return to IDLE only after the synchronised line is 1.
- Break: all data bits 0, parity bit (if present) 0, and first stop bit 0. Asserts both rx_break and rx_frame_err. rx_data = 0.
- Errored frames still deliver data with their flags; the consumer decides what to do with them.
- Handshake:
  - rx_valid holds until a clock with rx_ready=1, then clears on the next clock.
  - rx_data and the flags are stable while rx_valid=1.
  - rx_ready with rx_valid=0 is ignored.
- rx_overrun: sticky. rx_clr_ovr clears it; a set on the same cycle wins.
- rx_en=0 mid-frame: go to IDLE on the next clock, rx_busy=0, partial frame discarded, pending rx_valid untouched.
- srst mid-frame: full reset, pending data lost.

Optional Feature:
Macro: UART_RX_NOISE_FLAG_EN.
- When defined: rx_noise is set in the delivered status if any majority vote in the frame (start through last stop) had non-unanimous samples. It is qualified by rx_valid, like the other flags.
- When undefined: rx_noise is tied to 0 and the vote-disagreement logic is not built.

Test Plan:
1. 8N1, div=3, send 0xA5, rx_ready held low for 20 clocks. Required: rx_valid=1 with rx_data=0xA5, all flags 0, data stable for 20 clocks, rx_valid=0 one clock after rx_ready.
2. 7 data bits, even parity, 2 stop bits (7E2), div=0, send 0x35 with parity bit 1 (correct is 0). Required: rx_data=0x35, rx_parity_err=1, rx_frame_err=0. Repeat with a correct parity bit: no error.
3. Line low for 5 sample ticks then high, 8N1. Required: no rx_valid, rx_busy returns to 0 at the START majority point, and the next valid frame 0x3C is received correctly.
4. Line low for 12 bit times, 8N1. Required: rx_data=0x00, rx_frame_err=1, rx_break=1, rx_busy=1 until the line goes high. A following 0x81 frame is received cleanly.
5. Two back-to-back frames 0x11 and 0x22 with rx_ready=0. Required: rx_data stays 0x11, rx_overrun=1. Pulse rx_clr_ovr: rx_overrun=0. Assert srst mid-frame: all outputs 0 the next clock.
6. 8N1, single-tick glitch at sample 8 of data bit 2. Required: data correct (0x5A). rx_noise=1 with UART_RX_NOISE_FLAG_EN defined, 0 without it.
